// File: rtl/memory_8bit.sv
// Single-port synchronous RAM with a post-reset clear sweep.
// After reset every location is written to zero, one per clock, before the
// array accepts accesses. Each READY edge performs one registered read or
// write-first write; `done` marks that `q` holds the result of an access.
module memory_8bit #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] w,
    input  logic              enable,
    output logic [DATA_W-1:0] q,
    output logic              done
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        StClear,
        StReady
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0]  q_d;
    logic               done_d;

    // Single write port shared by the clear sweep and normal writes.
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;

    logic [DATA_W-1:0]  mem [DEPTH];

    // Next-state, output and write-port decode.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        q_d       = q;
        done_d    = done;
        mem_we    = 1'b0;
        mem_waddr = a;
        mem_wdata = w;
        unique case (state_q)
            StClear: begin
                // Access inputs are ignored while the array is being cleared.
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
                clr_ptr_d = clr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                q_d       = '0;
                done_d    = 1'b0;
                if (clr_ptr_q == {ADDR_W{1'b1}}) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                done_d = 1'b1;
                if (enable) begin
                    mem_we = 1'b1;
                    q_d    = w;       // write-first: new data shows on q
                end else begin
                    q_d    = mem[a];  // contents before this edge
                end
            end
            default: begin
                state_d = StClear;
            end
        endcase
    end

    // Control state and output registers; reset restarts the sweep.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StClear;
            clr_ptr_q <= '0;
            q         <= '0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            q         <= q_d;
            done      <= done_d;
        end
    end

    // Storage array; reset suppresses any write on that edge.
    always_ff @(posedge clock) begin
        if (!reset && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_memory_8bit.sv
// Self-checking bench for memory_8bit using a reference array and an
// expected-result queue filled when each access is driven.
module tb_memory_8bit;

    logic       clock;
    logic       reset;
    logic [7:0] a;
    logic [7:0] w;
    logic       enable;
    logic [7:0] q;
    logic       done;

    int n_tests;
    int n_fail;

    logic [7:0] model [256];
    logic [7:0] exp_q [$];

    memory_8bit #(
        .ADDR_W(8),
        .DATA_W(8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .a     (a),
        .w     (w),
        .enable(enable),
        .q     (q),
        .done  (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        exp_q.delete();
    endtask

    // One READY access: push the expectation, clock it, pop it back out.
    task automatic access(input logic [7:0] addr, input logic [7:0] data, input logic en,
                          output logic [7:0] got_q, output logic got_done,
                          output logic [7:0] want_q);
        a      = addr;
        w      = data;
        enable = en;
        exp_q.push_back(en ? data : model[addr]);
        if (en) model[addr] = data;
        tick();
        got_q    = q;
        got_done = done;
        want_q   = exp_q.pop_front();
        enable   = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] gq, wq;
        logic       gd;
        logic [7:0] addrs [3];
        addrs[0] = 8'h00; addrs[1] = 8'h55; addrs[2] = 8'hFF;
        reset = 1'b1; enable = 1'b0; a = 8'h00; w = 8'h00;
        clear_model();
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (q !== 8'h00 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d q=%h done=%b want q=00 done=0", i, q, done);
            end
        end
        reset = 1'b0;
        for (int e = 1; e <= 256; e++) begin
            tick();
            n_tests++;
            if (q !== 8'h00 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep E%0d q=%h done=%b want q=00 done=0", e, q, done);
            end
        end
        for (int i = 0; i < 3; i++) begin
            access(addrs[i], 8'h00, 1'b0, gq, gd, wq);
            n_tests++;
            if (gq !== wq || gd !== 1'b1) begin
                n_fail++;
                $display("FAIL post_sweep_read a=%h q=%h done=%b want q=%h done=1",
                         addrs[i], gq, gd, wq);
            end
        end
    endtask

    task automatic test_write_read();
        logic [7:0] gq, wq;
        logic       gd;
        access(8'h55, 8'hA5, 1'b1, gq, gd, wq);
        n_tests++;
        if (gq !== wq || gd !== 1'b1) begin
            n_fail++;
            $display("FAIL write_first q=%h done=%b want q=%h done=1", gq, gd, wq);
        end
        access(8'h55, 8'h00, 1'b0, gq, gd, wq);
        n_tests++;
        if (gq !== wq) begin
            n_fail++;
            $display("FAIL read_back_55 q=%h want %h", gq, wq);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] gq, wq;
        logic       gd;
        logic [7:0] ad [5];
        logic [7:0] dt [5];
        logic       en [5];
        ad[0] = 8'h0A; dt[0] = 8'h3C; en[0] = 1'b1;
        ad[1] = 8'h01; dt[1] = 8'h7E; en[1] = 1'b1;
        ad[2] = 8'h0A; dt[2] = 8'h00; en[2] = 1'b0;
        ad[3] = 8'h01; dt[3] = 8'h00; en[3] = 1'b0;
        ad[4] = 8'h19; dt[4] = 8'h00; en[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            access(ad[i], dt[i], en[i], gq, gd, wq);
            n_tests++;
            if (gq !== wq) begin
                n_fail++;
                $display("FAIL back_to_back step=%0d a=%h q=%h want %h", i, ad[i], gq, wq);
            end
        end
    endtask

    task automatic test_boundary();
        logic [7:0] gq, wq;
        logic       gd;
        logic [7:0] ad [4];
        logic [7:0] dt [4];
        logic       en [4];
        ad[0] = 8'h00; dt[0] = 8'h11; en[0] = 1'b1;
        ad[1] = 8'hFF; dt[1] = 8'hEE; en[1] = 1'b1;
        ad[2] = 8'h00; dt[2] = 8'h00; en[2] = 1'b0;
        ad[3] = 8'hFF; dt[3] = 8'h00; en[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            access(ad[i], dt[i], en[i], gq, gd, wq);
            n_tests++;
            if (gq !== wq) begin
                n_fail++;
                $display("FAIL boundary step=%0d a=%h q=%h want %h", i, ad[i], gq, wq);
            end
        end
        // Alternate write/read on one address; q must track the latest write.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            d = 8'(i * 37 + 5);
            access(8'h33, (i % 2 == 0) ? d : 8'h00, (i % 2 == 0), gq, gd, wq);
            n_tests++;
            if (gq !== wq) begin
                n_fail++;
                $display("FAIL alternate step=%0d q=%h want %h", i, gq, wq);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] gq, wq;
        logic       gd;
        reset = 1'b1;
        enable = 1'b1; a = 8'h55; w = 8'h99;  // must not write while in reset
        clear_model();
        for (int i = 0; i < 50; i++) begin
            tick();
            n_tests++;
            if (q !== 8'h00 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset cyc=%0d q=%h done=%b want q=00 done=0", i, q, done);
            end
        end
        reset = 1'b0; enable = 1'b0;
        for (int e = 1; e <= 256; e++) begin
            tick();
            n_tests++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL resweep_done E%0d done=%b want 0", e, done);
            end
        end
        access(8'h55, 8'h00, 1'b0, gq, gd, wq);
        n_tests++;
        if (gq !== wq || gd !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset_55 q=%h done=%b want q=%h done=1", gq, gd, wq);
        end
        access(8'h0A, 8'h00, 1'b0, gq, gd, wq);
        n_tests++;
        if (gq !== wq) begin
            n_fail++;
            $display("FAIL after_reset_0a q=%h want %h", gq, wq);
        end
    endtask

    task automatic test_sweep_ignore();
        logic [7:0] gq, wq;
        logic       gd;
        reset = 1'b1;
        clear_model();
        tick();
        reset = 1'b0;
        // Access inputs held active through the whole sweep must be ignored.
        enable = 1'b1; a = 8'h10; w = 8'hFF;
        for (int e = 1; e <= 256; e++) begin
            tick();
            n_tests++;
            if (q !== 8'h00 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_ignore E%0d q=%h done=%b want q=00 done=0", e, q, done);
            end
        end
        access(8'h10, 8'h00, 1'b0, gq, gd, wq);
        n_tests++;
        if (gq !== wq || gd !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_ignore_read q=%h done=%b want q=%h done=1", gq, gd, wq);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        enable  = 1'b0;
        a       = 8'h00;
        w       = 8'h00;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_boundary();
        test_mid_reset();
        test_sweep_ignore();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_8bit.md
# memory_8bit

Single-port 256 x 8 synchronous RAM used as coefficient/sample storage in the adaptive filter datapath. It provides a registered read or write access every clock once initialised. After reset it clears every location to zero by sweeping through the array. `done` reports that the block is initialised and `q` holds valid data.

## Interface
Parameters:
- `ADDR_W`, default 8: address width; depth = 2^ADDR_W (256).
- `DATA_W`, default 8: data width.

Ports:
- Clocking and reset are fixed: single clock `clock`, rising edge; `reset` synchronous, active-high.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high; aborts any activity and restarts the clear sweep.
- `a`  in  ADDR_W (8)  access address.
- `w`  in  DATA_W (8)  write data.
- `enable`  in  1  1 = write `w` to `mem[a]`; 0 = read `mem[a]`.
- `q`  out  DATA_W (8)  registered access result.
- `done`  out  1  registered; 1 = array initialised and `q` reflects a completed access.

## Operation
- Storage: `mem[0..255]`, 8 bits per entry. Internal clear pointer `clr_ptr` is ADDR_W bits.
- States:
  - CLEAR: initialisation sweep.
  - READY: normal access.
- Reset, sampled high on an edge:
  - state ← CLEAR, `clr_ptr` ← 0, `q` ← 0x00, `done` ← 0.
  - While `reset` stays high, the block holds in this condition and `mem` is not written.
- CLEAR, with `reset` low:
  - Each edge writes 0x00 to `mem[clr_ptr]`, then `clr_ptr` ← `clr_ptr`+1.
  - The edge that clears entry 255 moves the state to READY.
  - `a`, `w`, `enable` are ignored. `q` stays 0x00 and `done` stays 0.
- READY: one access per edge.
  - `enable`=1: `mem[a]` ← `w`; `q` ← `w` (write-first; the new data appears on `q`).
  - `enable`=0: `q` ← `mem[a]` (contents as of before this edge).
  - `done` ← 1 on the first READY access and stays 1 until the next reset.
- Addresses wrap naturally; all 8-bit values of `a` are valid. No out-of-range case exists.
- Contents persist indefinitely in READY. Only a reset sweep clears them.
- State before the first reset is undefined. Integration must reset the block after power-up.

## Timing
- Reset to outputs: `q`=0x00 and `done`=0 after the first edge with `reset` high.
- Reset release: the edges where `reset` is low are numbered E1, E2, …
  - E1..E256 clear entries 0..255; E256 also enters READY.
  - E257 performs the first access. `done`=1 and `q` are valid after E257.
- Access latency: 1 cycle. Inputs sampled at edge N give a result on `q` after edge N.
- Write followed by read of the same address on the next edge returns the written data, with no bubble.
- Reset mid-sweep or mid-operation takes priority over everything that edge. The sweep restarts from entry 0 after release, and all prior contents are lost.
- Edges with `reset` and `enable` both high perform no write.

## Test plan
- Reset 2 cycles then release: `done`=0 and `q`=0x00 through E256; `done`=1 after E257; reads of 0x00, 0x55 and 0xFF return 0x00.
- In READY, `a`=0x55, `w`=0xA5, `enable`=1 → `q`=0xA5 next edge. Then `enable`=0, `a`=0x55 → `q`=0xA5.
- Writes of 0x0A←0x3C and 0x01←0x7E on back-to-back edges, then reads → 0x3C, 0x7E. An unwritten address 0x19 reads 0x00.
- Boundary addresses: write 0x00←0x11 and 0xFF←0xEE, read back → 0x11, 0xEE. Alternate write/read to the same address each cycle → `q` always equals the latest written value.
- Reset mid-operation after the writes above: `reset`=1 for 50 cycles → `q`=0x00 and `done`=0 throughout. After release and the 256-cycle sweep, address 0x55 reads 0x00.
- During the sweep, drive `enable`=1, `a`=0x10, `w`=0xFF → ignored. After `done`=1, reading 0x10 returns 0x00.
